// File: rtl/uart_fifo_top.sv
// Buffered UART: TX/RX FIFOs, programmable 16x baud tick, RTS/CTS flow control,
// per-character parity/framing flags and a sticky overrun flag.
module uart_fifo_top #(
  parameter int CLK_HZ       = 100000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int RTS_THRESH   = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 baud_div,
  input  logic [1:0]                  data_bit_num,
  input  logic                        stop_bit_num,
  input  logic                        parity_en,
  input  logic                        parity_type,
  input  logic                        tx_wr_en,
  input  logic [7:0]                  tx_wr_data,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        tx_busy,
  input  logic                        rx_rd_en,
  output logic [7:0]                  rx_rd_data,
  output logic                        rx_rd_perr,
  output logic                        rx_rd_ferr,
  output logic                        rx_empty,
  output logic                        rx_full,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        rx_overrun,
  input  logic                        clr_overrun,
  input  logic                        rx,
  input  logic                        cts_n,
  output logic                        tx,
  output logic                        rts_n
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int DEF_DIV = CLK_HZ / (DEFAULT_BAUD * 16) - 1;
  localparam logic [TXW:0] TX_FULL_LVL = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL_LVL = (RXW+1)'(RX_DEPTH);
  localparam logic [RXW:0] RTS_LVL     = (RXW+1)'(RTS_THRESH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Baud tick; the divisor is re-sampled only at wrap so a change never shortens a period
  logic [15:0] baud_cnt_reg, div_reg;
  wire  [15:0] div_sel = (baud_div == 16'd0) ? 16'(DEF_DIV) : baud_div;
  wire         tick    = (baud_cnt_reg == div_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt_reg <= 16'd0;
      div_reg      <= div_sel;
    end else if (tick) begin
      baud_cnt_reg <= 16'd0;
      div_reg      <= div_sel;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 16'd1;
    end
  end

  logic [1:0] cts_sync_reg, rx_sync_reg;
  logic       rx_prev_reg;
  wire        rx_s = rx_sync_reg[1];

  // TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  wire          tx_push = tx_wr_en && !tx_full;
  assign tx_level = tx_wr_ptr_reg - tx_rd_ptr_reg;
  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == TX_FULL_LVL);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[TXW-1:0]] <= tx_wr_data;
  end

  // TX framing
  state_t     tx_state_reg;
  logic [3:0] tx_tcnt_reg;
  logic [2:0] tx_bit_reg, tx_last_reg;
  logic [7:0] tx_shift_reg;
  logic       tx_par_reg, tx_pen_reg, tx_stop2_reg, tx_line_reg, tx_busy_reg;
  wire  [7:0] data_mask = 8'hff >> (2'd3 - data_bit_num);
  wire  [7:0] tx_masked = tx_mem[tx_rd_ptr_reg[TXW-1:0]] & data_mask;
  wire        tx_launch = tick && (tx_state_reg == S_IDLE) && !tx_empty && !cts_sync_reg[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      cts_sync_reg  <= 2'b11;
      tx_state_reg  <= S_IDLE;
      tx_tcnt_reg   <= 4'd0;
      tx_bit_reg    <= 3'd0;
      tx_last_reg   <= 3'd0;
      tx_shift_reg  <= 8'd0;
      tx_par_reg    <= 1'b0;
      tx_pen_reg    <= 1'b0;
      tx_stop2_reg  <= 1'b0;
      tx_line_reg   <= 1'b1;
      tx_busy_reg   <= 1'b0;
    end else begin
      cts_sync_reg <= {cts_sync_reg[0], cts_n};
      if (tx_push)   tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_launch) tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      if (tx_launch) begin
        tx_state_reg <= S_START;
        tx_tcnt_reg  <= 4'd0;
        tx_last_reg  <= 3'd4 + {1'b0, data_bit_num};
        tx_shift_reg <= tx_masked;
        tx_par_reg   <= (^tx_masked) ^ parity_type;
        tx_pen_reg   <= parity_en;
        tx_stop2_reg <= stop_bit_num;
        tx_line_reg  <= 1'b0;
        tx_busy_reg  <= 1'b1;
      end else if (tick && tx_state_reg != S_IDLE) begin
        tx_tcnt_reg <= tx_tcnt_reg + 4'd1;
        if (tx_tcnt_reg == 4'd15) begin
          case (tx_state_reg)
            S_START: begin
              tx_state_reg <= S_DATA;
              tx_bit_reg   <= 3'd0;
              tx_line_reg  <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
            end
            S_DATA: begin
              if (tx_bit_reg != tx_last_reg) begin
                tx_bit_reg   <= tx_bit_reg + 3'd1;
                tx_line_reg  <= tx_shift_reg[0];
                tx_shift_reg <= tx_shift_reg >> 1;
              end else if (tx_pen_reg) begin
                tx_state_reg <= S_PARITY;
                tx_line_reg  <= tx_par_reg;
              end else begin
                tx_state_reg <= S_STOP;
                tx_line_reg  <= 1'b1;
                tx_bit_reg   <= 3'd0;
              end
            end
            S_PARITY: begin
              tx_state_reg <= S_STOP;
              tx_line_reg  <= 1'b1;
              tx_bit_reg   <= 3'd0;
            end
            S_STOP: begin
              if (tx_stop2_reg && tx_bit_reg == 3'd0) begin
                tx_bit_reg <= 3'd1;
              end else begin
                tx_state_reg <= S_IDLE;
                tx_busy_reg  <= 1'b0;
              end
            end
            default: tx_state_reg <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign tx      = tx_line_reg;
  assign tx_busy = tx_busy_reg;

  // RX framing: sample counter restarts at each sample point, so every later sample lands mid-bit
  state_t     rx_state_reg;
  logic [3:0] rx_tcnt_reg;
  logic [2:0] rx_bit_reg, rx_last_reg;
  logic [7:0] rx_data_reg;
  logic       rx_pacc_reg, rx_pen_reg, rx_ptype_reg, rx_perr_reg, rx_push_reg;
  logic [9:0] rx_entry_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_reg  <= 2'b11;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= S_IDLE;
      rx_tcnt_reg  <= 4'd0;
      rx_bit_reg   <= 3'd0;
      rx_last_reg  <= 3'd0;
      rx_data_reg  <= 8'd0;
      rx_pacc_reg  <= 1'b0;
      rx_pen_reg   <= 1'b0;
      rx_ptype_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_push_reg  <= 1'b0;
      rx_entry_reg <= 10'd0;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], rx};
      rx_prev_reg <= rx_s;
      rx_push_reg <= 1'b0;
      case (rx_state_reg)
        S_IDLE: begin
          if (rx_prev_reg && !rx_s) begin
            rx_state_reg <= S_START;
            rx_tcnt_reg  <= 4'd0;
            rx_last_reg  <= 3'd4 + {1'b0, data_bit_num};
            rx_pen_reg   <= parity_en;
            rx_ptype_reg <= parity_type;
            rx_data_reg  <= 8'd0;
            rx_pacc_reg  <= 1'b0;
            rx_perr_reg  <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_tcnt_reg == 4'd7) begin
              rx_tcnt_reg  <= 4'd0;
              rx_bit_reg   <= 3'd0;
              rx_state_reg <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_tcnt_reg <= rx_tcnt_reg + 4'd1;
            end
          end
        end
        default: begin
          if (tick) begin
            rx_tcnt_reg <= rx_tcnt_reg + 4'd1;
            if (rx_tcnt_reg == 4'd15) begin
              case (rx_state_reg)
                S_DATA: begin
                  rx_data_reg[rx_bit_reg] <= rx_s;
                  rx_pacc_reg <= rx_pacc_reg ^ rx_s;
                  rx_bit_reg  <= rx_bit_reg + 3'd1;
                  if (rx_bit_reg == rx_last_reg)
                    rx_state_reg <= rx_pen_reg ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                  rx_perr_reg  <= rx_s ^ rx_pacc_reg ^ rx_ptype_reg;
                  rx_state_reg <= S_STOP;
                end
                S_STOP: begin
                  rx_push_reg  <= 1'b1;
                  rx_entry_reg <= {!rx_s, rx_perr_reg, rx_data_reg};
                  rx_state_reg <= S_IDLE;
                end
                default: rx_state_reg <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  // RX FIFO; a pop on the same cycle frees the slot a full-FIFO push needs
  logic [9:0]   rx_mem [RX_DEPTH];
  logic [RXW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic         rx_overrun_reg, rts_n_reg;
  wire          rx_pop    = rx_rd_en && !rx_empty;
  wire          rx_accept = rx_push_reg && (!rx_full || rx_pop);
  wire  [9:0]   rx_head   = rx_mem[rx_rd_ptr_reg[RXW-1:0]];

  assign rx_level = rx_wr_ptr_reg - rx_rd_ptr_reg;
  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == RX_FULL_LVL);

  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem[rx_wr_ptr_reg[RXW-1:0]] <= rx_entry_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr_ptr_reg  <= '0;
      rx_rd_ptr_reg  <= '0;
      rx_overrun_reg <= 1'b0;
      rts_n_reg      <= 1'b0;
    end else begin
      if (rx_accept) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)    rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      if (rx_push_reg && !rx_accept) rx_overrun_reg <= 1'b1;
      else if (clr_overrun)          rx_overrun_reg <= 1'b0;
      rts_n_reg <= (rx_level >= RTS_LVL);
    end
  end

  assign rx_rd_data = rx_empty ? 8'h00 : rx_head[7:0];
  assign rx_rd_perr = rx_empty ? 1'b0  : rx_head[8];
  assign rx_rd_ferr = rx_empty ? 1'b0  : rx_head[9];
  assign rx_overrun = rx_overrun_reg;
  assign rts_n      = rts_n_reg;
endmodule

// File: tb/tb_uart_fifo_top.sv
// Directed bench for uart_fifo_top at baud_div=3 (64 clocks per bit); RX entries
// are predicted into a scoreboard queue when stimulus is driven.
module tb_uart_fifo_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  data_bit_num = 2'd3;
  logic        stop_bit_num = 1'b0, parity_en = 1'b0, parity_type = 1'b0;
  logic        tx_wr_en = 1'b0;
  logic [7:0]  tx_wr_data = 8'd0;
  logic        tx_full, tx_empty, tx_busy;
  logic [4:0]  tx_level, rx_level;
  logic        rx_rd_en = 1'b0;
  logic [7:0]  rx_rd_data;
  logic        rx_rd_perr, rx_rd_ferr, rx_empty, rx_full, rx_overrun;
  logic        clr_overrun = 1'b0;
  logic        cts_n = 1'b0;
  logic        tx, rts_n;
  logic        rx_drv = 1'b1, lb = 1'b0;
  wire         rx_line = lb ? tx : rx_drv;

  int          checks = 0, fails = 0;
  logic [9:0]  exp_q[$];

  uart_fifo_top dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bit_num(data_bit_num),
    .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_level(tx_level), .tx_busy(tx_busy), .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
    .rx_rd_perr(rx_rd_perr), .rx_rd_ferr(rx_rd_ferr), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_level(rx_level), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun), .rx(rx_line),
    .cts_n(cts_n), .tx(tx), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_wr_en = 1'b1;
    tx_wr_data = d;
    step(1);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_tx_fall(input string tag, input int max_wait);
    int n = 0;
    while (tx !== 1'b0 && n < max_wait) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, tx}, 32'd0);
  endtask

  task automatic hold_check(input string tag, input int n);
    int lows = 0;
    repeat (n) begin
      step(1);
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  // Samples every bit of one TX frame at its midpoint, plus the exact start-bit length.
  task automatic check_tx_frame(input string tag, input logic [7:0] d, input int nbits,
                                input bit pen, input bit ptype, input bit stop2,
                                input int max_wait, input bit raise_cts);
    logic par;
    par = ptype;
    for (int i = 0; i < nbits; i++) par ^= d[i];
    wait_tx_fall({tag, "_start"}, max_wait);
    step(63);
    check({tag, "_startlen"}, {31'd0, tx}, 32'd0);
    step(1);
    check({tag, "_bit0edge"}, {31'd0, tx}, {31'd0, d[0]});
    if (raise_cts) cts_n = 1'b1;
    step(32);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) step(64);
      check({tag, "_data"}, {31'd0, tx}, {31'd0, d[i]});
    end
    if (pen) begin
      step(64);
      check({tag, "_parity"}, {31'd0, tx}, {31'd0, par});
    end
    step(64);
    check({tag, "_stop1"}, {30'd0, tx, tx_busy}, 32'd3);
    if (stop2) begin
      step(64);
      check({tag, "_stop2"}, {30'd0, tx, tx_busy}, 32'd3);
    end
    $display("tx frame %s data=%02h bits=%0d", tag, d, nbits);
  endtask

  // Drives one frame on rx (1 stop bit) with optional corrupted parity/stop.
  task automatic send_rx(input logic [7:0] d, input int nbits, input bit pen, input bit ptype,
                         input bit flip_par, input bit bad_stop);
    logic par;
    par = ptype ^ flip_par;
    rx_drv = 1'b0;
    step(64);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = d[i];
      par ^= d[i];
      step(64);
    end
    if (pen) begin
      rx_drv = par;
      step(64);
    end
    rx_drv = !bad_stop;
    step(64);
    rx_drv = 1'b1;
    step(64);
    $display("rx frame driven data=%02h bits=%0d flip_par=%0d bad_stop=%0d", d, nbits, flip_par, bad_stop);
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (rx_empty !== 1'b0 && n < 3000) begin
      step(1);
      n++;
    end
    check({tag, "_avail"}, {31'd0, rx_empty}, 32'd0);
  endtask

  task automatic drain_rx(input string tag);
    logic [9:0] expv;
    wait_rx(tag);
    check({tag, "_sb"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (rx_empty === 1'b0 && exp_q.size() != 0) begin
      expv = exp_q.pop_front();
      check(tag, {22'd0, rx_rd_ferr, rx_rd_perr, rx_rd_data}, {22'd0, expv});
      $display("rx entry %s data=%02h perr=%0d ferr=%0d", tag, rx_rd_data, rx_rd_perr, rx_rd_ferr);
      rx_rd_en = 1'b1;
      step(1);
      rx_rd_en = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_flags", {26'd0, tx_busy, tx_empty, tx_full, rx_empty, rx_full, rx_overrun}, 32'h14);
    check("rst_levels", {22'd0, tx_level, rx_level}, 32'd0);
    check("rst_rd", {22'd0, rx_rd_ferr, rx_rd_perr, rx_rd_data}, 32'd0);
    check("rst_rts", {31'd0, rts_n}, 32'd0);
    rst_n = 1'b1;
    step(4);

    // 8N1 loopback of 0xA5
    lb = 1'b1;
    push_tx(8'hA5);
    exp_q.push_back({2'b00, 8'hA5});
    check_tx_frame("a5", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 200, 1'b0);
    wait_rx("a5_lvl");
    check("a5_rx_level", {27'd0, rx_level}, 32'd1);
    drain_rx("a5_rx");

    // 7 data bits, odd parity, 2 stop bits
    step(64);
    data_bit_num = 2'd2; parity_en = 1'b1; parity_type = 1'b1; stop_bit_num = 1'b1;
    push_tx(8'h7F);
    exp_q.push_back({2'b00, 8'h7F});
    check_tx_frame("7o2", 8'h7F, 7, 1'b1, 1'b1, 1'b1, 200, 1'b0);
    drain_rx("7o2_rx");
    step(40);
    check("7o2_busy_clr", {31'd0, tx_busy}, 32'd0);

    // Corrupted parity bit on rx
    lb = 1'b0;
    step(64);
    exp_q.push_back({2'b01, 8'h7F});
    send_rx(8'h7F, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    drain_rx("perr_rx");

    // Framing error
    data_bit_num = 2'd3; parity_en = 1'b0; parity_type = 1'b0; stop_bit_num = 1'b0;
    exp_q.push_back({2'b10, 8'h3C});
    send_rx(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_rx("ferr_rx");
    step(64);

    // Overrun: 17 frames, no reads
    for (int k = 0; k < 17; k++) begin
      logic [7:0] d;
      d = 8'h40 + 8'(k);
      if (k < 16) exp_q.push_back({2'b00, d});
      send_rx(d, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovr_level", {27'd0, rx_level}, (k < 16) ? k + 1 : 16);
      check("ovr_rts", {31'd0, rts_n}, (k + 1 >= 12) ? 1 : 0);
      check("ovr_flag", {31'd0, rx_overrun}, (k == 16) ? 1 : 0);
    end
    check("ovr_full", {31'd0, rx_full}, 32'd1);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    check("ovr_clear", {31'd0, rx_overrun}, 32'd0);
    for (int k = 0; k < 16; k++) drain_rx("ovr_rx");
    step(1);
    check("ovr_rts_release", {31'd0, rts_n}, 32'd0);
    check("ovr_empty", {31'd0, rx_empty}, 32'd1);

    // CTS flow control
    lb = 1'b1;
    cts_n = 1'b1;
    step(4);
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    exp_q.push_back({2'b00, 8'h11});
    exp_q.push_back({2'b00, 8'h22});
    exp_q.push_back({2'b00, 8'h33});
    hold_check("cts_hold", 800);
    check("cts_level", {27'd0, tx_level}, 32'd3);
    cts_n = 1'b0;
    check_tx_frame("fc1", 8'h11, 8, 1'b0, 1'b0, 1'b0, 100, 1'b0);
    check_tx_frame("fc2", 8'h22, 8, 1'b0, 1'b0, 1'b0, 48, 1'b1);
    hold_check("cts_mid_hold", 800);
    check("cts_mid_level", {26'd0, tx_busy, tx_level}, 32'd1);
    cts_n = 1'b0;
    check_tx_frame("fc3", 8'h33, 8, 1'b0, 1'b0, 1'b0, 100, 1'b0);
    for (int k = 0; k < 3; k++) drain_rx("fc_rx");

    // Start-bit glitch
    lb = 1'b0;
    step(64);
    rx_drv = 1'b0;
    step(2);
    rx_drv = 1'b1;
    step(300);
    check("glitch_empty", {26'd0, rx_empty, rx_level}, 32'h20);

    // Reset in the middle of a TX frame with both FIFOs occupied
    send_rx(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_rx_level", {27'd0, rx_level}, 32'd1);
    push_tx(8'h55); push_tx(8'h66);
    wait_tx_fall("pre_rst_start", 200);
    step(30);
    check("pre_rst_tx", {30'd0, tx, tx_busy}, 32'd1);
    rst_n = 1'b0;
    step(1);
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_flags", {26'd0, tx_busy, tx_empty, tx_full, rx_empty, rx_full, rx_overrun}, 32'h14);
    check("mid_rst_levels", {22'd0, tx_level, rx_level}, 32'd0);
    check("mid_rst_rd", {22'd0, rx_rd_ferr, rx_rd_perr, rx_rd_data}, 32'd0);
    check("mid_rst_rts", {31'd0, rts_n}, 32'd0);
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo_top.md
Name: uart_fifo_top

Overview:
- Next-generation UART top with independent TX and RX FIFOs, a runtime-programmable baud divisor and RTS/CTS hardware flow control.
- Reports errors per received character: parity and framing errors are stored with each RX FIFO entry; overrun is a sticky flag.
- Sits between a host bus adapter (push/pop FIFO interface) and the serial pins; it replaces the unbuffered UART top in new designs.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- DEFAULT_BAUD, 9600, baud rate used when baud_div == 0.
- TX_DEPTH, 16, TX FIFO entries; power of 2, ≥2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, ≥2.
- RTS_THRESH, 12, RX level at or above which rts_n deasserts; 1..RX_DEPTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- baud_div  in  16  tick period minus 1, where tick = 16x bit rate; 0 selects the default, CLK_HZ/(DEFAULT_BAUD*16)-1.
- data_bit_num  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
- stop_bit_num  in  1  stop bits: 0=1 bit, 1=2 bits.
- parity_en  in  1  parity bit enable.
- parity_type  in  1  parity sense: 0=even, 1=odd.
- tx_wr_en  in  1  push tx_wr_data into the TX FIFO.
- tx_wr_data  in  8  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx_empty  out  1  TX FIFO empty.
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- tx_busy  out  1  a frame is on the line.
- rx_rd_en  in  1  pop the RX FIFO head entry.
- rx_rd_data  out  8  head entry data (show-ahead).
- rx_rd_perr  out  1  head entry parity error.
- rx_rd_ferr  out  1  head entry framing error.
- rx_empty  out  1  RX FIFO empty.
- rx_full  out  1  RX FIFO full.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- rx_overrun  out  1  sticky: a received frame was dropped.
- clr_overrun  in  1  clears rx_overrun.
- rx  in  1  serial input, asynchronous.
- cts_n  in  1  peer clear-to-send, active low.
- tx  out  1  serial output.
- rts_n  out  1  request-to-send, active low.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state is sampled on the rising edge of clk.
- Reset values: tx=1, rts_n=0, tx_busy=0, tx_empty=1, rx_empty=1, tx_full=0, rx_full=0, both levels 0, rx_overrun=0, rx_rd_*=0. Both FIFOs are emptied.
- Reset mid-frame aborts the frame immediately; tx reads 1 from the first edge that samples rst_n=0.
- Baud tick:
  - Free-running counter; pulses one cycle every (div+1) clocks, where div is baud_div or the default.
  - A change to baud_div takes effect at the next counter wrap.
- Frame format: start bit 0; N data bits, LSB first; optional parity bit; stop bits of 1. Each bit is 16 ticks.
  - Even parity: parity bit = XOR of the N data bits. Odd parity: the inverse.
- Configuration latch: data_bit_num, stop_bit_num, parity_en and parity_type are latched at TX frame launch and at RX start detection. Changes mid-frame do not affect the current frame.
- TX FIFO:
  - A push is accepted only when !tx_full. A push while full is dropped and no state changes.
  - Simultaneous push and pop are both honoured, provided the push is accepted.
- TX launch:
  - Condition: TX idle, FIFO not empty, cts_n==0 (through a 2-flop synchroniser), all on a tick cycle.
  - On that cycle the head is popped and tx_busy is set. The start bit is driven from the next cycle for exactly 16*(div+1) clocks.
  - tx_busy clears on the cycle the last stop bit ends. The next launch may occur on the following tick.
  - cts_n rising mid-frame does not interrupt the frame; it only blocks the next launch.
  - Only the low N bits of a data byte are sent.
- TX FSM: IDLE → START → DATA (N bits) → PARITY (only if enabled) → STOP (1 or 2 bits) → IDLE.
- RX input: rx passes through a 2-flop synchroniser.
- RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE→START on a synchronised 1→0 edge; the tick count restarts at 0.
  - At tick 7 of the start bit, rx must still be 0. Otherwise return to IDLE (glitch reject).
  - Data, parity and stop bits are sampled at tick 15 after each preceding sample point, i.e. at each bit's midpoint.
  - At the midpoint of the first stop bit, an entry {ferr, perr, data} is pushed and the FSM returns to IDLE. No second stop bit is checked.
  - ferr = stop sample was 0. perr = parity mismatch; perr is 0 when parity is disabled.
  - Data bits above N are 0 in the stored entry.
- RX FIFO:
  - A push while full, with no pop that cycle, drops the frame and sets rx_overrun.
  - A push while full with rx_rd_en=1 on the same cycle succeeds.
  - A pop while empty is ignored.
  - rx_overrun stays set until clr_overrun. If a set and a clear occur on the same cycle, set wins.
- rts_n: registered; 1 when rx_level ≥ RTS_THRESH, else 0. It updates the cycle after the level changes.

Test Plan:
- Loopback (tx→rx), baud_div=3, 8N1, push 0xA5 → tx low for 64 clocks per bit, bits 1,0,1,0,0,1,0,1, then stop; RX entry 0xA5 with perr=0, ferr=0; rx_level=1.
- 7 data bits, odd parity, 2 stop bits, push 0x7F → parity bit 0; stop bits 1,1; RX data 0x7F; injecting a flipped parity bit gives perr=1.
- Framing error: drive a 0 on the stop bit of a frame carrying 0x3C → entry 0x3C with ferr=1.
- Overrun: RX_DEPTH=16, send 17 frames without reading → rx_full=1, rx_overrun=1, the 17th frame dropped; rts_n=1 from level 12; clr_overrun → 0.
- Flow control: cts_n=1 with 3 bytes queued → tx stays 1. Release cts_n → 3 back-to-back frames. Raising cts_n mid-frame 2 → frame 2 completes, frame 3 is held.
- Glitch and reset: a 2-clock low pulse on rx → no entry. Assert rst_n=0 mid-TX-frame → tx=1 next edge, FIFOs empty, all outputs at reset values.
